// File: rtl/prt_dp_pkg.sv
// rtl/prt_dp_pkg.sv - shared DisplayPort link symbol constants, LFSR helper and symbol type
package prt_dp_pkg;

   localparam logic [7:0] SYM_BS = 8'hBC;
   localparam logic [7:0] SYM_BE = 8'hFB;
   localparam logic [7:0] SYM_SR = 8'h1C;
   localparam logic [7:0] SYM_SS = 8'h5C;
   localparam logic [7:0] SYM_SE = 8'hFD;

   localparam logic [15:0] LFSR_SEED = 16'hFFFF;
   // x^5 + x^4 + x^3 + 1 feedback taps for the Galois shift
   localparam logic [15:0] LFSR_POLY = 16'h0039;

   localparam int SR_PERIOD     = 512;
   localparam int SR_PERIOD_SIM = 8;

   typedef struct packed {
      logic       k;
      logic [7:0] dat;
   } sym_t;

   function automatic logic [15:0] lfsr_step8(input logic [15:0] lfsr);
      logic [15:0] s;
      s = lfsr;
      for (int i = 0; i < 8; i++) begin
         s = {s[14:0], 1'b0} ^ (s[15] ? LFSR_POLY : 16'h0000);
      end
      return s;
   endfunction

endpackage

// File: rtl/prt_dptx_scrm_sym.sv
// rtl/prt_dptx_scrm_sym.sv - combinational single-symbol SR substitution and scrambling step
module prt_dptx_scrm_sym
   import prt_dp_pkg::*;
#(
   parameter int CNT_W = 9
) (
   input  sym_t             sym_i,
   input  logic [15:0]      lfsr_i,
   input  logic [CNT_W-1:0] cnt_i,
   output sym_t             sym_o,
   output logic [15:0]      lfsr_o,
   output logic [CNT_W-1:0] cnt_o,
   output logic             sr_o
);

   logic [7:0] key;

   always_comb begin
      for (int b = 0; b < 8; b++) begin
         key[b] = lfsr_i[15-b];
      end
   end

   always_comb begin
      sym_o  = sym_i;
      lfsr_o = lfsr_step8(lfsr_i);
      cnt_o  = cnt_i;
      sr_o   = 1'b0;
      if (sym_i.k) begin
         if (sym_i.dat == SYM_BS) begin
            cnt_o = cnt_i + 1'b1;
            if (cnt_i == '0) begin
               sym_o.dat = SYM_SR;
               lfsr_o    = LFSR_SEED;
               sr_o      = 1'b1;
            end
         end else if (sym_i.dat == SYM_SR) begin
            // upstream SR still resynchronises the receiver, so reseed here too
            lfsr_o = LFSR_SEED;
         end
      end else begin
         sym_o.dat = sym_i.dat ^ key;
      end
   end

endmodule

// File: rtl/prt_dptx_scrm.sv
// rtl/prt_dptx_scrm.sv - per-lane DP TX scrambler with periodic BS-to-SR substitution
module prt_dptx_scrm
   import prt_dp_pkg::*;
#(
   parameter int P_SIM = 0,
   parameter int P_SPL = 2
) (
   input  logic               CLK_IN,
   input  logic               RST_IN,
   input  logic               CTL_EN_IN,
   input  logic [P_SPL-1:0]   LNK_K_IN,
   input  logic [8*P_SPL-1:0] LNK_DAT_IN,
   output logic [P_SPL-1:0]   LNK_K_OUT,
   output logic [8*P_SPL-1:0] LNK_DAT_OUT,
   output logic               STA_SR_OUT
);

   localparam int CNT_W = (P_SIM != 0) ? $clog2(SR_PERIOD_SIM) : $clog2(SR_PERIOD);

   logic [15:0]      lfsr_c [P_SPL+1];
   logic [CNT_W-1:0] cnt_c  [P_SPL+1];
   sym_t             sym_c  [P_SPL];
   logic [P_SPL-1:0] sr_c;

   logic [P_SPL-1:0]   k_d,    k_q;
   logic [8*P_SPL-1:0] dat_d,  dat_q;
   logic               sr_d,   sr_q;
   logic [15:0]        lfsr_d, lfsr_q;
   logic [CNT_W-1:0]   cnt_d,  cnt_q;

   assign lfsr_c[0] = lfsr_q;
   assign cnt_c[0]  = cnt_q;

   // symbols are chained in order so each sees the LFSR/count left by its predecessor
   for (genvar s = 0; s < P_SPL; s++) begin : g_sym
      prt_dptx_scrm_sym #(
         .CNT_W(CNT_W)
      ) u_sym (
         .sym_i  ('{k: LNK_K_IN[s], dat: LNK_DAT_IN[8*s +: 8]}),
         .lfsr_i (lfsr_c[s]),
         .cnt_i  (cnt_c[s]),
         .sym_o  (sym_c[s]),
         .lfsr_o (lfsr_c[s+1]),
         .cnt_o  (cnt_c[s+1]),
         .sr_o   (sr_c[s])
      );
   end

   always_comb begin
      k_d    = LNK_K_IN;
      dat_d  = LNK_DAT_IN;
      sr_d   = 1'b0;
      lfsr_d = LFSR_SEED;
      cnt_d  = '0;
      if (CTL_EN_IN) begin
         for (int s = 0; s < P_SPL; s++) begin
            k_d[s]          = sym_c[s].k;
            dat_d[8*s +: 8] = sym_c[s].dat;
         end
         sr_d   = |sr_c;
         lfsr_d = lfsr_c[P_SPL];
         cnt_d  = cnt_c[P_SPL];
      end
   end

   always_ff @(posedge CLK_IN or negedge RST_IN) begin
      if (!RST_IN) begin
         k_q    <= '0;
         dat_q  <= '0;
         sr_q   <= 1'b0;
         lfsr_q <= LFSR_SEED;
         cnt_q  <= '0;
      end else begin
         k_q    <= k_d;
         dat_q  <= dat_d;
         sr_q   <= sr_d;
         lfsr_q <= lfsr_d;
         cnt_q  <= cnt_d;
      end
   end

   assign LNK_K_OUT   = k_q;
   assign LNK_DAT_OUT = dat_q;
   assign STA_SR_OUT  = sr_q;

endmodule

// File: tb/tb_prt_dptx_scrm.sv
// tb/tb_prt_dptx_scrm.sv - directed checks of prt_dptx_scrm at 1, 2 and 4 symbols per clock
module tb_prt_dptx_scrm;

   localparam logic [7:0] KSEQ [16] = '{8'hFF, 8'h17, 8'hC0, 8'h14, 8'hB2, 8'hE7, 8'h02, 8'h82,
                                        8'h72, 8'h6E, 8'h28, 8'hA6, 8'hBE, 8'h6D, 8'hBF, 8'h8D};

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic [0:0]  k1, k1o;
   logic [7:0]  d1, d1o;
   logic [1:0]  k2, k2o;
   logic [15:0] d2, d2o;
   logic [3:0]  k4, k4o;
   logic [31:0] d4, d4o;
   logic        sr1o, sr2o, sr4o;

   int n_chk = 0;
   int n_err = 0;
   int nsr;

   always #5 clk = ~clk;

   prt_dptx_scrm #(.P_SIM(0), .P_SPL(1)) u_dut1 (
      .CLK_IN(clk), .RST_IN(rst_n), .CTL_EN_IN(en), .LNK_K_IN(k1), .LNK_DAT_IN(d1),
      .LNK_K_OUT(k1o), .LNK_DAT_OUT(d1o), .STA_SR_OUT(sr1o));
   prt_dptx_scrm #(.P_SIM(0), .P_SPL(2)) u_dut2 (
      .CLK_IN(clk), .RST_IN(rst_n), .CTL_EN_IN(en), .LNK_K_IN(k2), .LNK_DAT_IN(d2),
      .LNK_K_OUT(k2o), .LNK_DAT_OUT(d2o), .STA_SR_OUT(sr2o));
   prt_dptx_scrm #(.P_SIM(0), .P_SPL(4)) u_dut4 (
      .CLK_IN(clk), .RST_IN(rst_n), .CTL_EN_IN(en), .LNK_K_IN(k4), .LNK_DAT_IN(d4),
      .LNK_K_OUT(k4o), .LNK_DAT_OUT(d4o), .STA_SR_OUT(sr4o));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] ks(input logic k, input logic [7:0] d);
      return {23'b0, k, d};
   endfunction

   function automatic logic [31:0] sym1();
      return {23'b0, k1o[0], d1o};
   endfunction

   function automatic logic [31:0] sym2(input int s);
      return {23'b0, k2o[s], d2o[8*s +: 8]};
   endfunction

   function automatic logic [31:0] sym4(input int s);
      return {23'b0, k4o[s], d4o[8*s +: 8]};
   endfunction

   // expected output for symbol j of "BS then zeros" after enable
   function automatic logic [31:0] kexp(input int j);
      if (j == 0) return ks(1'b1, 8'h1C);
      return ks(1'b0, KSEQ[j-1]);
   endfunction

   task automatic zero_in();
      k1 = '0; d1 = '0; k2 = '0; d2 = '0; k4 = '0; d4 = '0;
   endtask

   initial begin
      rst_n = 1'b0;
      en    = 1'b1;
      zero_in();

      for (int i = 0; i < 3; i++) begin
         k1 = 1'($urandom); d1 = 8'($urandom);
         k2 = 2'($urandom); d2 = 16'($urandom);
         k4 = 4'($urandom); d4 = $urandom;
         tick();
         chk("rst_dat2", 32'(d2o), 32'h0);
         chk("rst_k2", 32'(k2o), 32'h0);
         chk("rst_sr2", 32'(sr2o), 32'h0);
         chk("rst_dat4", d4o, 32'h0);
      end

      en    = 1'b0;
      rst_n = 1'b1;
      k2 = 2'b01; d2 = 16'h5ABC;
      #1;
      chk("first_lat", 32'(d2o), 32'h0);
      tick();
      chk("dis_dat_a", 32'(d2o), 32'h5ABC);
      chk("dis_k_a", 32'(k2o), 32'h1);
      chk("dis_sr_a", 32'(sr2o), 32'h0);
      k2 = 2'b10; d2 = 16'hBC5A;
      tick();
      chk("dis_dat_b", 32'(d2o), 32'hBC5A);
      chk("dis_k_b", 32'(k2o), 32'h2);
      chk("dis_sr_b", 32'(sr2o), 32'h0);

      en = 1'b1;
      for (int c = 0; c < 17; c++) begin
         zero_in();
         if (c == 0) begin
            k1 = 1'b1;  d1 = 8'hBC;
            k2 = 2'b01; d2 = 16'h00BC;
            k4 = 4'b0001; d4 = 32'h0000_00BC;
         end
         tick();
         chk("kseq1", sym1(), kexp(c));
         chk("kseq_sr1", 32'(sr1o), 32'(c == 0));
         for (int s = 0; s < 2; s++)
            if (2*c + s <= 16) chk("kseq2", sym2(s), kexp(2*c + s));
         chk("kseq_sr2", 32'(sr2o), 32'(c == 0));
         for (int s = 0; s < 4; s++)
            if (4*c + s <= 16) chk("kseq4", sym4(s), kexp(4*c + s));
         chk("kseq_sr4", 32'(sr4o), 32'(c == 0));
      end

      zero_in();
      k2 = 2'b01; d2 = 16'h001C;
      tick();
      chk("up_sr0", sym2(0), ks(1'b1, 8'h1C));
      chk("up_sr1", sym2(1), ks(1'b0, 8'hFF));
      chk("up_sr_flag", 32'(sr2o), 32'h0);
      k2 = 2'b11; d2 = 16'h5CFB;
      tick();
      chk("kpass_be", sym2(0), ks(1'b1, 8'hFB));
      chk("kpass_ss", sym2(1), ks(1'b1, 8'h5C));
      k2 = 2'b00; d2 = 16'h0000;
      tick();
      chk("kpass_d0", sym2(0), ks(1'b0, 8'h14));
      chk("kpass_d1", sym2(1), ks(1'b0, 8'hB2));

      en = 1'b0;
      tick();
      en  = 1'b1;
      nsr = 0;
      k2 = 2'b01; d2 = 16'h00BC;
      for (int i = 0; i < 1030; i++) begin
         tick();
         chk("cad_sym0", sym2(0), (i % 512 == 0) ? ks(1'b1, 8'h1C) : ks(1'b1, 8'hBC));
         chk("cad_sr", 32'(sr2o), 32'(i % 512 == 0));
         nsr += int'(sr2o);
      end
      chk("cad_sr_cnt", 32'(nsr), 32'd3);

      en = 1'b0;
      tick();
      en = 1'b1;
      for (int i = 0; i < 511; i++) tick();
      k2 = 2'b11; d2 = 16'hBCBC;
      tick();
      chk("two_bs0", sym2(0), ks(1'b1, 8'hBC));
      chk("two_bs1", sym2(1), ks(1'b1, 8'h1C));
      chk("two_bs_sr", 32'(sr2o), 32'h1);
      k2 = 2'b00; d2 = 16'h0000;
      tick();
      chk("two_bs_d0", sym2(0), ks(1'b0, 8'hFF));
      chk("two_bs_d1", sym2(1), ks(1'b0, 8'h17));

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/prt_dptx_scrm.md
Name: prt_dptx_scrm

Overview:
Per-lane DisplayPort TX scrambler and scrambler-reset inserter. It is the transmit-side counterpart of the RX descrambler.
- Accepts P_SPL 8b symbols per clock (data plus K flag) from the TX framer.
- Replaces every 512th BS (K28.5) with SR (K28.0).
- Scrambles data symbols with the DP LFSR and forwards the result to the PHY encoder.
- One instance per lane, inside the TX link top.

Parameters:
P_SIM, 0, 1 = SR substituted every 8th BS instead of every 512th (shortens simulation).
P_SPL, 2, symbols per lane per clock (1, 2 or 4).

Ports:
CLK_IN  in  1  link clock
RST_IN  in  1  reset, asynchronous, active-low
CTL_EN_IN  in  1  scrambler enable (link-clock domain, level)
LNK_K_IN  in  P_SPL  K flag per symbol, symbol 0 = earliest
LNK_DAT_IN  in  8*P_SPL  symbol data, symbol s at [8s+7:8s]
LNK_K_OUT  out  P_SPL  K flag out
LNK_DAT_OUT  out  8*P_SPL  scrambled data out
STA_SR_OUT  out  1  one-cycle pulse when at least one SR was inserted in the output word

Behaviour:
- Reset (RST_IN=0, asynchronous):
  - All outputs 0.
  - LFSR = 16'hFFFF.
  - BS counter = 0.
- Latency: exactly 1 clock from input to output. Every cycle is valid; there is no handshake or backpressure.
- LFSR:
  - Polynomial G(X)=X^16+X^5+X^4+X^3+1, Galois form.
  - One symbol step = 8 single-bit shifts.
  - Scrambled byte: out[b] = in[b] ^ lfsr[15-b], evaluated before the step.
  - Symbols within a word are processed in order 0..P_SPL-1, with the LFSR chained combinationally. Only the final state is registered.
- Per symbol, with CTL_EN_IN=1:
  - BS (K=1, 8'hBC) and BS counter == 0: emit SR (K=1, 8'h1C); LFSR becomes 16'hFFFF for the next symbol (no step).
  - BS (K=1, 8'hBC) and BS counter != 0: emit BS unchanged; step the LFSR.
  - Any other K symbol: pass through unscrambled; step the LFSR.
  - Data symbol (K=0): emit the scrambled byte; step the LFSR.
  - Input SR (K=1, 8'h1C) from upstream: pass through; LFSR reset to 16'hFFFF, as for an inserted SR.
- BS counter:
  - Width 9 bits (P_SIM=0) or 3 bits (P_SIM=1); wraps naturally (511->0, 7->0).
  - Increments once per BS symbol, including a BS that was converted to SR.
  - Multiple BS in one word each count, in symbol order. Each is evaluated against the running count, so at most one of them can hit count 0 in a word for P_SPL<=4 with period>=8.
- CTL_EN_IN=0:
  - Output = input delayed 1 clock, with no substitution and no scrambling.
  - LFSR is forced to 16'hFFFF and the BS counter to 0 every cycle.
  - STA_SR_OUT=0.
- Enable edges:
  - CTL_EN_IN rising: takes effect on the same input word. The first BS after enable becomes SR, which resynchronises the receiver immediately.
  - CTL_EN_IN falling mid-word: the whole word is treated as disabled.
- STA_SR_OUT is registered together with the output word.

Decomposition:
- Shared package prt_dp_pkg holds:
  - symbol constants: BS 8'hBC, BE 8'hFB, SR 8'h1C, SS 8'h5C, SE 8'hFD;
  - LFSR seed 16'hFFFF;
  - SR periods 512 and 8.
- Sub-module prt_dptx_scrm_sym: combinational single-symbol step.
  - Inputs: K, data, LFSR, count.
  - Outputs: K, data, next LFSR, next count, SR flag.
  - Instantiated P_SPL times in a chain.

Test Plan:
- Reset: hold RST_IN=0 with random input -> outputs 0, STA_SR_OUT=0; release -> first output appears 1 clock after the first input.
- Known sequence:
  - Stimulus: enable, send one BS (becomes SR), then 16 data symbols 8'h00.
  - Required output after the SR: FF 17 C0 14 B2 E7 02 82 72 6E 28 A6 BE 6D BF 8D.
  - Check with P_SPL=1, 2 and 4.
- SR cadence (P_SIM=0):
  - Stimulus: 1030 BS symbols interleaved with data.
  - Required: BS #0, #512 and #1024 emitted as 8'h1C K=1; all others 8'hBC; STA_SR_OUT pulses exactly 3 times.
- Disable pass-through: CTL_EN_IN=0, data 8'h5A and K 8'hBC -> output identical, 1 clock late; no SR. Re-enable -> next BS becomes SR.
- K symbols unscrambled: BE 8'hFB and SS 8'h5C (K=1) pass unchanged while the LFSR still advances. The data byte following them must match the reference-model sequence.
- Two BS in one P_SPL=2 word at counter=511 -> symbol 0 stays BS, symbol 1 becomes SR; the next data byte scrambles with 8'hFF.
